window_buffer_control: RTL

WINDOW_BUFFER_CONTROL -- requirements
Module: window_buffer_control

---
 rtl/window_buffer_control.sv | 133 +++++++++++++
 1 files changed

// File: rtl/window_buffer_control.sv
// -----------------------------------------------------------------------------
// window_buffer_control
//   Buffers a raster pixel stream into four circular line buffers. Once three
//   complete lines are present, it sweeps a 3x3 window across them, one window
//   per cycle, for the kernel_convolution stage.
//
// Ports
//   i_clock            : single clock, rising edge
//   i_reset            : synchronous, active-high reset
//   i_pixel_data       : one RGB332 pixel, raster order
//   i_pixel_data_valid : i_pixel_data is written this cycle
//   o_pixel_data       : 3x3 window, byte k = 3*row + col (row 0 = oldest line)
//   o_pixel_data_valid : o_pixel_data holds a new window this cycle
//   o_intr             : pulses with the last window of a row (request a line)
// -----------------------------------------------------------------------------
module window_buffer_control #(
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_W     = 9
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(LINE_WIDTH - 1);
  localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(LINE_WIDTH - 3);

  // Line storage is plain RAM: written directly, never reset.
  logic [7:0] line_mem [4][LINE_WIDTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_col_q, wr_col_d;
  logic [1:0]        wr_line_q, wr_line_d;
  logic [ADDR_W-1:0] rd_col_q, rd_col_d;
  logic [1:0]        rd_line_q, rd_line_d;
  logic [2:0]        lines_filled_q, lines_filled_d;
  logic [71:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              intr_q, intr_d;

  logic        wr_en, wr_done, rd_issue, rd_done;
  logic [71:0] win;

  always_comb begin
    // With all four buffers full the write target is the oldest read line,
    // so incoming pixels are dropped rather than corrupting the window.
    wr_en    = i_pixel_data_valid && (lines_filled_q != 3'd4);
    wr_done  = wr_en && (wr_col_q == WR_LAST);
    rd_issue = (state_q == READ);
    rd_done  = rd_issue && (rd_col_q == RD_LAST);

    wr_col_d  = wr_col_q;
    wr_line_d = wr_line_q;
    if (wr_en) begin
      wr_col_d = wr_done ? '0 : wr_col_q + 1'b1;
      if (wr_done) wr_line_d = wr_line_q + 2'd1;
    end

    lines_filled_d = lines_filled_q;
    case ({wr_done, rd_done})
      2'b10:   lines_filled_d = lines_filled_q + 3'd1;
      2'b01:   lines_filled_d = lines_filled_q - 3'd1;
      default: lines_filled_d = lines_filled_q;
    endcase

    state_d   = state_q;
    rd_col_d  = rd_col_q;
    rd_line_d = rd_line_q;
    case (state_q)
      IDLE: if (lines_filled_q >= 3'd3) state_d = READ;
      READ: begin
        rd_col_d = rd_col_q + 1'b1;
        if (rd_done) begin
          // Always fall back to IDLE: this is the single bubble between rows.
          state_d   = IDLE;
          rd_col_d  = '0;
          rd_line_d = rd_line_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[8*(3*r+c) +: 8] = line_mem[rd_line_q + 2'(r)][rd_col_q + ADDR_W'(c)];
      end
    end

    data_d  = rd_issue ? win : data_q;
    valid_d = rd_issue;
    intr_d  = rd_done;
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) line_mem[wr_line_q][wr_col_q] <= i_pixel_data;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= IDLE;
      wr_col_q       <= '0;
      wr_line_q      <= '0;
      rd_col_q       <= '0;
      rd_line_q      <= '0;
      lines_filled_q <= '0;
      data_q         <= '0;
      valid_q        <= 1'b0;
      intr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_col_q       <= wr_col_d;
      wr_line_q      <= wr_line_d;
      rd_col_q       <= rd_col_d;
      rd_line_q      <= rd_line_d;
      lines_filled_q <= lines_filled_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      intr_q         <= intr_d;
    end
  end

  assign o_pixel_data       = data_q;
  assign o_pixel_data_valid = valid_q;
  assign o_intr             = intr_q;

endmodule
